price_packet_parser: RTL

- Sits between the UART byte receiver and the trade strategy stage.
- Frames the 6-byte price transmission from the receiver's byte stream and checks it.
- Presents price_A / price_B with a single-cycle packet_valid strobe to the strategy stage.
- Rejects malformed frames: bad checksum, or a stalled link (inter-byte timeout).

---
 rtl/price_feed_pkg.sv | 25 ++
 rtl/price_packet_parser_rx_timeout.sv | 26 ++
 rtl/price_packet_parser.sv | 116 +++++++++++
 3 files changed

// File: rtl/price_feed_pkg.sv
// Shared types and constants for the price feed path
// (UART framing through to the strategy stage).
package price_feed_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hAA;
  localparam int PKT_LEN = 6;
  localparam int PRICE_W = 16;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_A_HI = 3'd1;
  localparam logic [2:0] S_A_LO = 3'd2;
  localparam logic [2:0] S_B_HI = 3'd3;
  localparam logic [2:0] S_B_LO = 3'd4;
  localparam logic [2:0] S_CHK  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE,
    ST_A_HI = S_A_HI,
    ST_A_LO = S_A_LO,
    ST_B_HI = S_B_HI,
    ST_B_LO = S_B_LO,
    ST_CHK  = S_CHK
  } state_t;

endpackage

// File: rtl/price_packet_parser_rx_timeout.sv
// Link watchdog: counts enabled cycles since the last clear
// and saturates at LIMIT, flagging expiry.
module rx_timeout #(
  parameter int LIMIT = 10000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || clr)
      cnt <= '0;
    else if (en && !expired)
      cnt <= cnt + W'(1);
  end

  assign expired = (cnt == W'(LIMIT));

endmodule

// File: rtl/price_packet_parser.sv
// Frames the 6-byte price packet from the UART byte stream,
// verifies its XOR checksum and publishes prices.
module price_packet_parser
  import price_feed_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYCLES = 10000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [PRICE_W-1:0] price_A,
  output logic [PRICE_W-1:0] price_B,
  output logic               packet_valid,
  output logic               chk_err,
  output logic               frame_err,
  output logic [15:0]        pkt_count
);

  state_t state, state_nx;

  logic [PRICE_W-1:0] shd_a, shd_b;
  logic [7:0]         sum;
  logic               pub, bad, tmo;
  logic               expired;

  rx_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (rx_valid || tmo || state == ST_IDLE),
    .en      (state != ST_IDLE),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  // A byte arriving on the expiry cycle takes priority.
  always_comb begin
    state_nx = state;
    pub      = 1'b0;
    bad      = 1'b0;
    tmo      = 1'b0;
    if (rx_valid) begin
      unique case (state)
        ST_IDLE:
          if (rx_data == SYNC_BYTE)
            state_nx = ST_A_HI;
        ST_A_HI: state_nx = ST_A_LO;
        ST_A_LO: state_nx = ST_B_HI;
        ST_B_HI: state_nx = ST_B_LO;
        ST_B_LO: state_nx = ST_CHK;
        ST_CHK: begin
          state_nx = ST_IDLE;
          pub      = (rx_data == sum);
          bad      = (rx_data != sum);
        end
        default: state_nx = ST_IDLE;
      endcase
    end else if (expired && state != ST_IDLE) begin
      state_nx = ST_IDLE;
      tmo      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      price_A      <= '0;
      price_B      <= '0;
      pkt_count    <= '0;
      packet_valid <= 1'b0;
      chk_err      <= 1'b0;
      frame_err    <= 1'b0;
      shd_a        <= '0;
      shd_b        <= '0;
      sum          <= '0;
    end else begin
      packet_valid <= pub;
      chk_err      <= bad;
      frame_err    <= tmo;
      if (pub) begin
        price_A   <= shd_a;
        price_B   <= shd_b;
        pkt_count <= pkt_count + 16'd1;
      end
      if (rx_valid) begin
        unique case (state)
          ST_IDLE: sum <= '0;
          ST_A_HI: begin
            shd_a[15:8] <= rx_data;
            sum         <= sum ^ rx_data;
          end
          ST_A_LO: begin
            shd_a[7:0] <= rx_data;
            sum        <= sum ^ rx_data;
          end
          ST_B_HI: begin
            shd_b[15:8] <= rx_data;
            sum         <= sum ^ rx_data;
          end
          ST_B_LO: begin
            shd_b[7:0] <= rx_data;
            sum        <= sum ^ rx_data;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
